// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: 32-step shift-add multiply or restoring divide on
// operand magnitudes, with sign correction applied once at the end into HI/LO.
//
//   state  | meaning
//   -------+----------------------------------------------------------
//   S_IDLE | waiting for start; HI/LO hold the last result
//   S_CALC | one multiply or divide iteration per cycle, WIDTH cycles
//   S_FIX  | negate signed results and write HI/LO, pulse done
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t             state_q, state_d;
    logic               is_div_q, is_div_d;
    logic               sign_lo_q, sign_lo_d;
    logic               sign_hi_q, sign_hi_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               is_signed, div_zero, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum, rem_sh, div_diff;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign is_signed = ~op[0];
    assign a_neg     = is_signed & operand_a[WIDTH-1];
    assign b_neg     = is_signed & operand_b[WIDTH-1];
    assign a_mag     = a_neg ? -operand_a : operand_a;
    assign b_mag     = b_neg ? -operand_b : operand_b;
    assign div_zero  = op[1] & (operand_b == '0);

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], a_q[WIDTH-1]};
    assign div_diff = rem_sh - {1'b0, b_q};

    assign prod_fix = sign_lo_q ? -acc_q : acc_q;
    assign quo_fix  = sign_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = sign_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        is_div_d  = is_div_q;
        sign_lo_d = sign_lo_q;
        sign_hi_d = sign_hi_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_CALC;
                    is_div_d = op[1];
                    acc_d    = '0;
                    cnt_d    = '0;
                    if (div_zero) begin
                        // Raw dividend and zero divisor leave quotient all-ones and remainder = dividend.
                        a_d       = operand_a;
                        b_d       = '0;
                        sign_lo_d = 1'b0;
                        sign_hi_d = 1'b0;
                    end else begin
                        a_d       = a_mag;
                        b_d       = b_mag;
                        sign_lo_d = a_neg ^ b_neg;
                        sign_hi_d = op[1] ? a_neg : (a_neg ^ b_neg);
                    end
                end
            end
            S_CALC: begin
                if (!is_div_q) begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    b_d   = b_q >> 1;
                end else begin
                    a_d = a_q << 1;
                    if (!div_diff[WIDTH])
                        acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    else
                        acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1))
                    state_d = S_FIX;
            end
            S_FIX: begin
                if (!is_div_q) begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            is_div_q  <= 1'b0;
            sign_lo_q <= 1'b0;
            sign_hi_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_div_q  <= is_div_d;
            sign_lo_q <= sign_lo_d;
            sign_hi_q <= sign_hi_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit for the datapath's MULT/MULTU/DIV/DIVU instructions. It takes two register operands and runs a fixed 32-iteration shift-add or restoring-divide sequence, holding results in architectural HI/LO registers. HI/LO feed the 32-bit 2:1 write-back select mux as the alternate data source for MFHI/MFLO. The control unit stalls on `busy`.

## Interface
- `WIDTH`, default 32: operand and result width; iteration count equals WIDTH.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: request; sampled only in IDLE.
- `op` input 2: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- `operand_a` input WIDTH: multiplicand or dividend; captured when `start` is accepted.
- `operand_b` input WIDTH: multiplier or divisor; captured when `start` is accepted.
- `busy` output 1: high while state is not IDLE.
- `done` output 1: one-cycle pulse when HI/LO are updated.
- `hi` output WIDTH: product upper half, or remainder.
- `lo` output WIDTH: product lower half, or quotient.

## Operation
- States:
  - IDLE: waits for `start`.
  - CALC: runs WIDTH iterations, counter 0..WIDTH-1.
  - FIX: applies sign correction and writes HI/LO.
- IDLE to CALC: `start`=1 on an edge.
  - Latch `op`.
  - Latch operand magnitudes: two's-complement absolute value for signed ops, raw value for unsigned ops.
  - Latch result signs:
    - MULT: product sign = a[31]^b[31].
    - DIV: quotient sign = a[31]^b[31]; remainder sign = a[31].
  - Clear the 2·WIDTH accumulator and the counter.
- CALC, multiply: each cycle, if the multiplier LSB is 1, add the multiplicand to the accumulator upper half; then shift {acc, multiplier} right by 1.
- CALC, divide (restoring): each cycle, shift {rem, quotient} left by 1, taking in the dividend MSB; trial-subtract the divisor; if the result is non-negative, keep it and set quotient LSB=1.
- CALC to FIX: taken after the iteration with counter = WIDTH-1.
- FIX to IDLE, unconditionally, with these writes:
  - Two's-complement-negate each result whose latched sign is 1.
  - Write `hi`/`lo`.
  - Assert `done` for the following cycle.
- Arithmetic rules:
  - Products are full 64-bit: {hi,lo}.
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
- Divide by zero (`operand_b`=0, DIV or DIVU): normal 32-cycle timing; result `lo`=32'hFFFF_FFFF, `hi`=`operand_a` as captured (unsigned pattern, no sign fix).
- Signed overflow: DIV 0x8000_0000 / 0xFFFF_FFFF gives `lo`=0x8000_0000, `hi`=0. This falls out of magnitude arithmetic and needs no special case.
- `start` while `busy`=1 is ignored; the operation in flight is unaffected.
- `hi`/`lo` change only on the FIX edge. They hold their value otherwise, including through ignored starts.

## Timing
- Reset (`reset_n`=0, asynchronous, any state including mid-CALC):
  - State returns to IDLE.
  - `busy`=0, `done`=0, `hi`=0, `lo`=0.
  - Counter and accumulator are cleared; the operation in flight is discarded.
- Start accepted at edge T0:
  - `busy`=1 from T0 until the edge T33 that leaves FIX.
  - CALC occupies edges T1..T32; FIX occupies edge T33.
  - In the cycle after T33: `hi`/`lo` are valid, `done`=1, `busy`=0.
- Latency is 34 clocks from the accepting edge to results valid.
- `done` is high for exactly one cycle and coincides with IDLE. A `start` sampled in that cycle is accepted, so back-to-back operations have a throughput of one per 34 cycles.
- Operands may change after T0 without effect.

## Test plan
- Reset mid-CALC: start MULTU 5×7, assert `reset_n`=0 at cycle 10 → `busy`=0, `hi`=`lo`=0 immediately; no `done` pulse follows.
- MULTU 0xFFFF_FFFF×0xFFFF_FFFF → after 34 cycles `hi`=0xFFFF_FFFE, `lo`=0x0000_0001, `done` high for one cycle.
- MULT −3×7 (0xFFFF_FFFD, 7) → `hi`=0xFFFF_FFFF, `lo`=0xFFFF_FFEB.
- DIV −7/2 → `lo`=0xFFFF_FFFD (−3), `hi`=0xFFFF_FFFF (−1). DIVU 100/7 → `lo`=14, `hi`=2.
- Divide by zero and overflow:
  - DIVU 0x1234/0 → `lo`=0xFFFF_FFFF, `hi`=0x1234.
  - DIV 0x8000_0000/0xFFFF_FFFF → `lo`=0x8000_0000, `hi`=0.
- Handshake:
  - `start` pulsed at cycle 5 of a busy period → ignored; result matches the first op.
  - `start` held high continuously → a new op is accepted in each `done` cycle; results arrive every 34 cycles.
